lock_ctrl: RTL and testbench
============================

LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requesters sharing the lock (legal 2..8).
REQ-002 Parameter HOLD_CYCLES, default 8, meaning the maximum cycles a grant is held when the timeout feature is compiled in (legal 1..255).
REQ-003 Port clk, input, 1, meaning the clock; all state SHALL update on posedge clk.
REQ-004 Port rst, input, 1, meaning the reset: synchronous, active-high.
REQ-005 Port req, input, NUM_REQ, meaning per-requester access request, level-sensitive.
REQ-006 Port done, input, NUM_REQ, meaning a one-cycle pulse from the granted requester to release the lock.
REQ-007 Port grant, output, NUM_REQ, meaning one-hot, high while the lock is opened for that requester.
REQ-008 Port open, output, 1, meaning the open command to the lock, one-cycle pulse.
REQ-009 Port close, output, 1, meaning the close command to the lock, one-cycle pulse.
REQ-010 Port busy, output, 1, meaning high in every state except IDLE.
REQ-011 Port timeout, output, 1, meaning a one-cycle pulse when a grant is revoked by the hold timer.

Function
REQ-012 The FSM SHALL have the states IDLE, OPEN, WAIT_OPEN, GRANT, CLOSE and WAIT_CLOSE.
REQ-013 IDLE SHALL go to OPEN when any req bit is high, registering the winner index; otherwise it SHALL stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: the search starts at (last_winner+1) mod NUM_REQ, and the first set req bit wins.
REQ-015 OPEN SHALL go to WAIT_OPEN, WAIT_OPEN SHALL go to GRANT, CLOSE SHALL go to WAIT_CLOSE, and WAIT_CLOSE SHALL go to IDLE, each unconditionally.
REQ-016 open SHALL be 1 only in OPEN, close SHALL be 1 only in CLOSE, and grant[winner] SHALL be 1 only in GRANT; all outputs SHALL decode from registered state.
REQ-017 Latency: with req rising in cycle 0 while in IDLE, open SHALL be high in cycle 1 and grant in cycles 3 and later.
REQ-018 GRANT SHALL go to CLOSE when done[winner]=1 or req[winner]=0.
REQ-019 done or req changes on non-winner bits SHALL be ignored outside IDLE.
REQ-020 A winner that drops req during OPEN or WAIT_OPEN SHALL still pass through GRANT, with grant high for exactly one cycle, then go to CLOSE.
REQ-021 After WAIT_CLOSE the FSM SHALL return to IDLE for at least one cycle before re-arbitrating, so the minimum spacing between open pulses is 6 cycles.
REQ-022 last_winner SHALL update on the IDLE-to-OPEN transition only.
REQ-023 If done and the timer expiry occur in the same cycle, the FSM SHALL go to CLOSE and timeout SHALL stay 0.
REQ-024 grant SHALL never have more than one bit set, and open and close SHALL never both be high.

Reset
REQ-025 On rst=1 at posedge clk, state SHALL become IDLE, last_winner SHALL become NUM_REQ-1 (requester 0 has first priority), and the hold counter SHALL clear.
REQ-026 During and after reset, grant, open, close, busy and timeout SHALL all be 0.
REQ-027 Reset in any state, including GRANT, SHALL abort with no close pulse issued.

Configuration
REQ-028 With macro LOCK_CTRL_TIMEOUT_EN defined, an 8-bit counter SHALL clear on GRANT entry and increment each GRANT cycle.
REQ-029 With LOCK_CTRL_TIMEOUT_EN defined, after HOLD_CYCLES cycles in GRANT with no release, the FSM SHALL go to CLOSE and timeout SHALL pulse in the first CLOSE cycle.
REQ-030 Without LOCK_CTRL_TIMEOUT_EN, the counter SHALL not exist, GRANT SHALL be held indefinitely until done or req drops, and timeout SHALL be tied to 0.

Verification
REQ-031 Reset, then req=0001 in cycle 0, then done[0] in cycle 6 -> open high in cycle 1; grant=0001 in cycles 3..6; close high in cycle 7; busy low in cycle 9.
REQ-032 req=0110 held, each grant released by done after 2 cycles -> grants in order 0010, 0100, 0010, each preceded by exactly one open pulse.
REQ-033 LOCK_CTRL_TIMEOUT_EN defined, HOLD_CYCLES=4, req=1000 held with no done -> grant=1000 for 4 cycles, then close and timeout high together in one cycle.
REQ-034 rst asserted in the second GRANT cycle -> next cycle all outputs 0 and no close pulse; req=0001 afterwards -> requester 0 granted first.
REQ-035 req[2] pulsed high for one cycle only in IDLE -> open, grant=0100 for exactly 1 cycle, then close.
REQ-036 done[1] pulsed while grant=0001 -> ignored and grant stays 0001; with LOCK_CTRL_TIMEOUT_EN undefined and req held, grant stays high for 300 cycles.

Source files
------------

// File: rtl/lock_if.sv
// Requester-side handshake bundle for lock_ctrl: requests/releases in, lock commands and grants out.
interface lock_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] grant;
  logic               open;
  logic               close;
  logic               busy;
  logic               timeout;

  modport master (
    output req, done,
    input  grant, open, close, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, open, close, busy, timeout
  );
endinterface

// File: rtl/lock_ctrl.sv
// Round-robin lock arbiter: open -> grant -> close sequence per winner, all outputs registered.
// Optional grant hold timer compiled in with LOCK_CTRL_TIMEOUT_EN.
module lock_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 8
) (
  input logic   clk,
  input logic   rst,
  lock_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    WAIT_OPEN,
    GRANT,
    CLOSE,
    WAIT_CLOSE
  } state_t;

  state_t          state;
  logic [IW-1:0]   last_winner;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   pick;
  logic            found;
  logic            rel;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    pick  = last_winner;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && bus.req[rr_idx(last_winner, i)]) begin
        pick  = rr_idx(last_winner, i);
        found = 1'b1;
      end
    end
  end

  assign rel = bus.done[winner] | ~bus.req[winner];

`ifdef LOCK_CTRL_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  logic [7:0] hold_cnt;
  logic       timeout_q;
  assign bus.timeout = timeout_q;
`else
  logic unused_hold;
  assign unused_hold = ^8'(HOLD_CYCLES);
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= IW'(NUM_REQ - 1);
      winner      <= '0;
      bus.grant   <= '0;
      bus.open    <= 1'b0;
      bus.close   <= 1'b0;
      bus.busy    <= 1'b0;
`ifdef LOCK_CTRL_TIMEOUT_EN
      hold_cnt    <= 8'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      bus.open  <= 1'b0;
      bus.close <= 1'b0;
`ifdef LOCK_CTRL_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state       <= OPEN;
            winner      <= pick;
            last_winner <= pick;
            bus.open    <= 1'b1;
            bus.busy    <= 1'b1;
          end
        end
        OPEN: state <= WAIT_OPEN;
        WAIT_OPEN: begin
          state     <= GRANT;
          bus.grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
`ifdef LOCK_CTRL_TIMEOUT_EN
          hold_cnt  <= 8'd0;
`endif
        end
        GRANT: begin
          // A release in the expiry cycle wins, so timeout stays low then.
          if (rel) begin
            state     <= CLOSE;
            bus.grant <= '0;
            bus.close <= 1'b1;
          end
`ifdef LOCK_CTRL_TIMEOUT_EN
          else if (hold_cnt == HOLD_LAST) begin
            state     <= CLOSE;
            bus.grant <= '0;
            bus.close <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt  <= hold_cnt + 8'd1;
          end
`endif
        end
        CLOSE: state <= WAIT_CLOSE;
        WAIT_CLOSE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: expected grants queued at stimulus time, popped on each new grant.
module tb_lock_ctrl;
`ifdef LOCK_CTRL_TIMEOUT_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 8;
`endif
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lock_if #(.NUM_REQ(N)) bus ();

  lock_ctrl #(.NUM_REQ(N), .HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [N-1:0] sb_q[$];
  logic [N-1:0] sb_exp;
  logic [N-1:0] prev_grant = '0;

  // Monitor: every new grant must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.grant !== '0 && prev_grant === '0) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_grant got=%b expected=none", bus.grant);
        end else begin
          sb_exp = sb_q.pop_front();
          if (bus.grant !== sb_exp) begin
            fails++;
            $display("FAIL sb_grant got=%b expected=%b", bus.grant, sb_exp);
          end
        end
      end
      tests++;
      if ($countones(bus.grant) > 1 || (bus.open === 1'b1 && bus.close === 1'b1)) begin
        fails++;
        $display("FAIL exclusive grant=%b open=%b close=%b", bus.grant, bus.open, bus.close);
      end
    end
    prev_grant = bus.grant;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [N+3:0] outs();
    return {bus.grant, bus.open, bus.close, bus.busy, bus.timeout};
  endfunction

  task automatic wait_grant(output int opens, output bit ok);
    opens = 0;
    ok    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.grant !== '0) begin
        ok = 1'b1;
        return;
      end
      if (bus.open === 1'b1) opens++;
      tick();
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s busy=%b expected=0 within 20 cycles", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.done = '0;
    tick(3);
    tests++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%b expected=0", outs());
    end
    rst = 1'b0;
    tick(2);
    tests++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL reset_idle got=%b expected=0", outs());
    end
  endtask

  task automatic test_basic();
    bus.req = 4'b0001;
    sb_q.push_back(4'b0001);
    tick();
    tests++;
    if ({bus.open, bus.busy} !== 2'b11) begin
      fails++;
      $display("FAIL basic_open got open,busy=%b expected=11", {bus.open, bus.busy});
    end
    tick();
    tests++;
    if ({bus.grant, bus.open} !== 5'b0) begin
      fails++;
      $display("FAIL basic_wait_open got grant,open=%b expected=00000", {bus.grant, bus.open});
    end
    for (int c = 3; c <= 6; c++) begin
      tick();
      tests++;
      if (bus.grant !== 4'b0001) begin
        fails++;
        $display("FAIL basic_grant cycle=%0d got=%b expected=0001", c, bus.grant);
      end
    end
    bus.done = 4'b0001;
    tick();
    bus.done = '0;
    bus.req = '0;
    tests++;
    if (bus.close !== 1'b1 || bus.grant !== '0) begin
      fails++;
      $display("FAIL basic_close got close=%b grant=%b expected close=1 grant=0000", bus.close, bus.grant);
    end
    tick();
    tests++;
    if ({bus.busy, bus.close} !== 2'b10) begin
      fails++;
      $display("FAIL basic_wait_close got busy,close=%b expected=10", {bus.busy, bus.close});
    end
    tick();
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle got busy=%b expected=0", bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order[3];
    int opens;
    bit ok;
    order[0] = 4'b0010;
    order[1] = 4'b0100;
    order[2] = 4'b0010;
    bus.req = 4'b0110;
    for (int k = 0; k < 3; k++) sb_q.push_back(order[k]);
    for (int k = 0; k < 3; k++) begin
      wait_grant(opens, ok);
      tests++;
      if (!ok || opens != 1) begin
        fails++;
        $display("FAIL rr_open_pulses grant=%0d ok=%0d got=%0d expected=1", k, ok, opens);
      end
      tick();
      bus.done = order[k];
      if (k == 2) bus.req = '0;
      tick();
      bus.done = '0;
    end
    wait_idle("rr_idle");
  endtask

  task automatic test_short_req();
    bus.req = 4'b0100;
    sb_q.push_back(4'b0100);
    tick();
    bus.req = '0;
    tests++;
    if (bus.open !== 1'b1) begin
      fails++;
      $display("FAIL short_open got=%b expected=1", bus.open);
    end
    tick(2);
    tests++;
    if (bus.grant !== 4'b0100) begin
      fails++;
      $display("FAIL short_grant got=%b expected=0100", bus.grant);
    end
    tick();
    tests++;
    if (bus.grant !== '0 || bus.close !== 1'b1) begin
      fails++;
      $display("FAIL short_close got grant=%b close=%b expected grant=0000 close=1", bus.grant, bus.close);
    end
    wait_idle("short_idle");
  endtask

  task automatic test_reset_in_grant();
    int opens;
    int closes;
    bit ok;
    bus.req = 4'b0001;
    sb_q.push_back(4'b0001);
    wait_grant(opens, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rst_pre_grant got=none expected=0001");
    end
    tick();
    rst = 1'b1;
    bus.req = '0;
    tick();
    tests++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL rst_abort_outputs got=%b expected=0", outs());
    end
    rst = 1'b0;
    closes = 0;
    repeat (4) begin
      tick();
      if (bus.close === 1'b1) closes++;
    end
    tests++;
    if (closes != 0) begin
      fails++;
      $display("FAIL rst_no_close got=%0d close pulses expected=0", closes);
    end
    // Requester 1 would win here if last_winner had not been reset.
    bus.req = 4'b0011;
    sb_q.push_back(4'b0001);
    wait_grant(opens, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rst_post_grant got=none expected=0001");
    end
    bus.done = 4'b0001;
    bus.req = '0;
    tick();
    bus.done = '0;
    wait_idle("rst_idle");
  endtask

  task automatic test_ignore();
    int opens;
    bit ok;
    bus.req = 4'b0001;
    sb_q.push_back(4'b0001);
    wait_grant(opens, ok);
    bus.done = 4'b0010;
    tick();
    tests++;
    if (bus.grant !== 4'b0001) begin
      fails++;
      $display("FAIL ignore_done got=%b expected=0001", bus.grant);
    end
    bus.done = '0;
    tick();
    tests++;
    if (bus.grant !== 4'b0001) begin
      fails++;
      $display("FAIL ignore_hold got=%b expected=0001", bus.grant);
    end
`ifndef LOCK_CTRL_TIMEOUT_EN
    begin
      int held;
      held = 0;
      repeat (300) begin
        tick();
        if (bus.grant === 4'b0001) held++;
      end
      tests++;
      if (held != 300) begin
        fails++;
        $display("FAIL hold_300 got=%0d grant cycles expected=300", held);
      end
    end
`endif
    bus.done = 4'b0001;
    tick();
    bus.done = '0;
    bus.req = '0;
    tests++;
    if (bus.close !== 1'b1 || bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL ignore_release got close=%b timeout=%b expected close=1 timeout=0", bus.close, bus.timeout);
    end
    wait_idle("ignore_idle");
  endtask

`ifdef LOCK_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int opens;
    int n;
    bit ok;
    bus.req = 4'b1000;
    sb_q.push_back(4'b1000);
    wait_grant(opens, ok);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.grant !== 4'b1000) break;
      n++;
      tick();
    end
    tests++;
    if (n != HOLD) begin
      fails++;
      $display("FAIL timeout_hold_len got=%0d expected=%0d", n, HOLD);
    end
    tests++;
    if ({bus.close, bus.timeout} !== 2'b11) begin
      fails++;
      $display("FAIL timeout_pulse got close,timeout=%b expected=11", {bus.close, bus.timeout});
    end
    bus.req = '0;
    tick();
    tests++;
    if (bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_one_cycle got=%b expected=0", bus.timeout);
    end
    wait_idle("timeout_idle");

    bus.req = 4'b1000;
    sb_q.push_back(4'b1000);
    wait_grant(opens, ok);
    tick(HOLD - 1);
    bus.done = 4'b1000;
    tick();
    tests++;
    if ({bus.close, bus.timeout} !== 2'b10) begin
      fails++;
      $display("FAIL timeout_done_tie got close,timeout=%b expected=10", {bus.close, bus.timeout});
    end
    bus.done = '0;
    bus.req = '0;
    wait_idle("tie_idle");
  endtask
`endif

  initial begin
    bus.req = '0;
    bus.done = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_short_req();
    test_reset_in_grant();
    test_ignore();
`ifdef LOCK_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    tick(2);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain got=%0d pending expected=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
